// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: run_ctrl state encoding and default parameters (STEP_WAIT only with RUN_CTRL_STEP_EN)
package run_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RST_HOLD,
    RUN,
`ifdef RUN_CTRL_STEP_EN
    STEP_WAIT,
`endif
    DONE
  } state_t;
  localparam int DEF_RST_CYCLES = 1;
  localparam int DEF_MAX_CYCLES = 2;
  localparam int DEF_CNT_W = 32;
endpackage

// File: rtl/run_ctrl_cnt.sv
// run_ctrl_cnt: saturating enabled-cycle counter with budget compare; limit flags the increment that reaches MAX_CYCLES
module run_ctrl_cnt
  import run_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             limit
);
  localparam logic [CNT_W:0] LIM = (CNT_W+1)'(MAX_CYCLES);
  logic [CNT_W:0] nxt;
  assign nxt = {1'b0, count} + (CNT_W+1)'(1);
  assign limit = inc && (MAX_CYCLES != 0) && (nxt == LIM);
  always_ff @(posedge clock)
    if (!reset || clr) count <= '0;
    else if (inc && !nxt[CNT_W]) count <= nxt[CNT_W-1:0];
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: core run controller (reset hold, free run or single step with RUN_CTRL_STEP_EN, halt/budget stop)
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step_mode,
  input  logic             step,
  input  logic             halt,
  output logic             core_reset,
  output logic             core_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             busy,
  output logic             done,
  output logic             timeout
);
  state_t state, state_n, run_st;
  logic [7:0] rcnt;
  logic go, last_rst, inc, limit;
  assign go = (state == IDLE || state == DONE) && start;
  assign last_rst = rcnt == 8'(RST_CYCLES - 1);
`ifdef RUN_CTRL_STEP_EN
  logic mode, step_q, pulse;
  always_ff @(posedge clock)
    if (!reset) begin
      mode <= 1'b0;
      step_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      step_q <= step;
      pulse <= state == STEP_WAIT && state_n == STEP_WAIT && step && !step_q;
      if (go) mode <= step_mode;
    end
  assign run_st = mode ? STEP_WAIT : RUN;
  assign inc = state == RUN || (state == STEP_WAIT && pulse);
`else
  logic unused_step;
  assign unused_step = step ^ step_mode;
  assign run_st = RUN;
  assign inc = state == RUN;
`endif
  always_comb begin
    state_n = go ? RST_HOLD
            : state == RST_HOLD ? (last_rst ? run_st : RST_HOLD)
            : (inc && (halt || limit)) ? DONE : state;
  end
  always_ff @(posedge clock)
    if (!reset) begin
      state <= IDLE;
      rcnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      rcnt <= state == RST_HOLD ? rcnt + 8'd1 : 8'd0;
      timeout <= go ? 1'b0 : (inc && !halt && limit) ? 1'b1 : timeout;
    end
  run_ctrl_cnt #(.MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)) u_cnt (
    .clock(clock),
    .reset(reset),
    .clr(go),
    .inc(inc),
    .count(cycle_count),
    .limit(limit)
  );
  assign core_reset = state == IDLE || state == RST_HOLD;
  assign core_en = inc;
  assign busy = !(state == IDLE || state == DONE);
  assign done = state == DONE;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: randomized self-checking bench for run_ctrl against a run-outcome reference model
module tb_run_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, step = 1'b0, step_mode = 1'b0;
  logic [3:0] start = '0, halt = '0;
  logic [3:0] cr, ce, bz, dn, to;
  logic [31:0] c0, c1, c2;
  logic [2:0] c3;
  int passed = 0, total = 0;
  int rstc [4] = '{1, 3, 1, 1};
  int maxc [4] = '{2, 100, 4, 0};
  int cw   [4] = '{32, 32, 32, 3};

  always #5 clk = ~clk;

  run_ctrl u0 (.clock(clk), .reset(rst_n), .start(start[0]), .step_mode(step_mode), .step(step), .halt(halt[0]),
               .core_reset(cr[0]), .core_en(ce[0]), .cycle_count(c0), .busy(bz[0]), .done(dn[0]), .timeout(to[0]));
  run_ctrl #(.RST_CYCLES(3), .MAX_CYCLES(100)) u1 (.clock(clk), .reset(rst_n), .start(start[1]), .step_mode(step_mode), .step(step), .halt(halt[1]),
               .core_reset(cr[1]), .core_en(ce[1]), .cycle_count(c1), .busy(bz[1]), .done(dn[1]), .timeout(to[1]));
  run_ctrl #(.MAX_CYCLES(4)) u2 (.clock(clk), .reset(rst_n), .start(start[2]), .step_mode(step_mode), .step(step), .halt(halt[2]),
               .core_reset(cr[2]), .core_en(ce[2]), .cycle_count(c2), .busy(bz[2]), .done(dn[2]), .timeout(to[2]));
  run_ctrl #(.MAX_CYCLES(0), .CNT_W(3)) u3 (.clock(clk), .reset(rst_n), .start(start[3]), .step_mode(step_mode), .step(step), .halt(halt[3]),
               .core_reset(cr[3]), .core_en(ce[3]), .cycle_count(c3), .busy(bz[3]), .done(dn[3]), .timeout(to[3]));

  function automatic int cnt(input int d);
    return d == 0 ? int'(c0) : d == 1 ? int'(c1) : d == 2 ? int'(c2) : int'({29'b0, c3});
  endfunction

  // run outcome: budget stops a run unless halt arrives on or before the budgeted cycle
  function automatic bit exp_to(input int m, input int h);
    return m != 0 && (h == 0 || h > m);
  endfunction

  function automatic int exp_cnt(input int m, input int h, input int w);
    int sat;
    sat = w >= 31 ? 32'h7fffffff : (1 << w) - 1;
    if (exp_to(m, h)) return m;
    return h > sat ? sat : h;
  endfunction

  task automatic do_run(input int d, input int h, input bit smode, output int nrst, output int nen, output bit ok);
    nrst = 0;
    nen = 0;
    ok = 1'b0;
    @(negedge clk);
    start[d] = 1'b1;
    step_mode = smode;
    @(negedge clk);
    start[d] = 1'b0;
    step_mode = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dn[d]) begin
        ok = 1'b1;
        break;
      end
      if (bz[d] && cr[d]) nrst++;
      halt[d] = 1'b0;
      if (ce[d]) begin
        nen++;
        halt[d] = (nen == h);
      end
      @(negedge clk);
    end
    halt[d] = 1'b0;
  endtask

  task automatic check_run(input string nm, input int d, input int h, input bit smode);
    int nrst, nen, ec;
    bit ok;
    do_run(d, h, smode, nrst, nen, ok);
    ec = exp_cnt(maxc[d], h, cw[d]);
    total++;
    if (ok !== 1'b1) $display("FAIL %s_done_timeout dut=%0d h=%0d no done within budget", nm, d, h);
    else passed++;
    total++;
    if (cnt(d) !== ec) $display("FAIL %s_count dut=%0d h=%0d got=%0d exp=%0d", nm, d, h, cnt(d), ec);
    else passed++;
    total++;
    if (to[d] !== exp_to(maxc[d], h)) $display("FAIL %s_timeout dut=%0d h=%0d got=%0b exp=%0b", nm, d, h, to[d], exp_to(maxc[d], h));
    else passed++;
    total++;
    if (nen !== (h != 0 && !exp_to(maxc[d], h) ? h : ec)) $display("FAIL %s_en_cycles dut=%0d h=%0d got=%0d exp=%0d", nm, d, h, nen, ec);
    else passed++;
    total++;
    if (nrst !== rstc[d]) $display("FAIL %s_rst_cycles dut=%0d got=%0d exp=%0d", nm, d, nrst, rstc[d]);
    else passed++;
    @(negedge clk);
    total++;
    if ({ce[d], bz[d], dn[d], cr[d]} !== 4'b0010) $display("FAIL %s_after_done dut=%0d en/busy/done/rst got=%4b exp=0010", nm, d, {ce[d], bz[d], dn[d], cr[d]});
    else passed++;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({cr, ce, bz, dn, to} !== {4'hf, 16'h0}) $display("FAIL reset_flags got=%h exp=%h", {cr, ce, bz, dn, to}, {4'hf, 16'h0});
    else passed++;
    total++;
    if ({c0, c1, c2, c3} !== '0) $display("FAIL reset_counts got=%0d/%0d/%0d/%0d exp=0", c0, c1, c2, c3);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_defaults;
    check_run("defaults", 0, 0, 1'b0);
  endtask

  task automatic test_halt;
    check_run("halt5", 1, 5, 1'b0);
    check_run("halt_at_budget", 2, 4, 1'b0);
    check_run("budget4", 2, 0, 1'b0);
    check_run("halt_first", 2, 1, 1'b0);
  endtask

  task automatic test_saturate;
    check_run("saturate", 3, 12, 1'b0);
  endtask

  task automatic test_start_ignored;
    bit seen = 1'b0;
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (c1 == 32'd5) seen = 1'b1;
      else @(negedge clk);
    end
    total++;
    if (!seen) $display("FAIL busy_start_wait count never reached 5, got=%0d", c1);
    else passed++;
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    total++;
    if ({c1, bz[1], ce[1], cr[1]} !== {32'd6, 3'b110}) $display("FAIL busy_start count/busy/en/rst got=%0d/%b%b%b exp=6/110", c1, bz[1], ce[1], cr[1]);
    else passed++;
    halt[1] = 1'b1;
    @(negedge clk);
    halt[1] = 1'b0;
    total++;
    if ({c1, dn[1], to[1]} !== {32'd7, 2'b10}) $display("FAIL busy_start_end count/done/timeout got=%0d/%b%b exp=7/10", c1, dn[1], to[1]);
    else passed++;
  endtask

`ifdef RUN_CTRL_STEP_EN
  task automatic test_step;
    int sched [20] = '{0,0,0,0,0,1,0,0,1,1,1,1,0,0,1,0,0,0,0,0};
    int edges = 0, nen = 0, prev = 0;
    bit fin = 1'b0;
    foreach (sched[i]) begin
      if (sched[i] == 1 && prev == 0) edges++;
      prev = sched[i];
    end
    @(negedge clk);
    start[1] = 1'b1;
    step_mode = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    step_mode = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (ce[1]) nen++;
      step = i < 20 ? sched[i][0] : 1'b0;
      @(negedge clk);
    end
    total++;
    if (nen !== edges) $display("FAIL step_en_cycles got=%0d exp=%0d", nen, edges);
    else passed++;
    total++;
    if ({c1, bz[1], dn[1]} !== {32'(edges), 2'b10}) $display("FAIL step_count_busy got=%0d/%b%b exp=%0d/10", c1, bz[1], dn[1], edges);
    else passed++;
    step = 1'b1;
    for (int i = 0; i < 6 && !fin; i++) begin
      @(negedge clk);
      halt[1] = ce[1];
      if (ce[1]) fin = 1'b1;
    end
    @(negedge clk);
    halt[1] = 1'b0;
    step = 1'b0;
    total++;
    if ({c1, dn[1], to[1]} !== {32'(edges + 1), 2'b10}) $display("FAIL step_halt count/done/timeout got=%0d/%b%b exp=%0d/10", c1, dn[1], to[1], edges + 1);
    else passed++;
  endtask
`else
  task automatic test_step;
    check_run("step_ignored", 1, 6, 1'b1);
  endtask
`endif

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      int d, h;
      d = $urandom_range(0, 2);
      h = $urandom_range(0, maxc[d] > 10 ? 10 : maxc[d] + 2);
      check_run("random", d, h, 1'b0);
    end
  endtask

  task automatic test_midrun_reset;
    int n = 0;
    @(negedge clk);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    for (int i = 0; i < 50 && n < 3; i++) begin
      if (ce[1]) n++;
      if (n < 3) @(negedge clk);
    end
    total++;
    if (n != 3) $display("FAIL midrun_wait got=%0d enabled cycles exp=3", n);
    else passed++;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({cr[1], ce[1], bz[1], dn[1], to[1], c1} !== {5'b10000, 32'd0}) $display("FAIL midrun_reset rst/en/busy/done/to=%b%b%b%b%b count=%0d exp 10000/0", cr[1], ce[1], bz[1], dn[1], to[1], c1);
    else passed++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_defaults;
    test_halt;
    test_saturate;
    test_start_ignored;
    test_step;
    test_random;
    test_midrun_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
